// File: rtl/mac_acc_if.sv
// Handshake bundle between the multiplier stage, the accumulator and writeback.
// The master side feeds products and drains results; the accumulator is the slave.
interface mac_acc_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_prod;
  logic signed [ACC_W-1:0]  bias;
  logic [3:0]               shift;
  logic                     relu_en;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic signed [OUT_W-1:0]  out_q;
  logic                     busy;

  modport master (
    output in_valid, in_prod, bias, shift, relu_en, out_ready,
    input  in_ready, out_valid, out_acc, out_q, busy
  );

  modport slave (
    input  in_valid, in_prod, bias, shift, relu_en, out_ready,
    output in_ready, out_valid, out_acc, out_q, busy
  );
endinterface

// File: rtl/mac_accumulator.sv
// Window accumulator: sums KSIZE signed products plus a bias, then
// emits the raw sum and a rounded, optionally ReLU'd, saturated byte.
module mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int KSIZE  = 9,
  parameter int OUT_W  = 8
) (
  input logic     clk,
  input logic     rst_n,
  mac_acc_if.slave io
);
  localparam int CW = 8;
  localparam logic [CW-1:0] LASTC = CW'(KSIZE - 1);
  localparam logic signed [ACC_W:0] QMAX =
    $signed((ACC_W+1)'(2**(OUT_W-1) - 1));
  localparam logic signed [ACC_W:0] QMIN = -QMAX - 1;

  logic [CW-1:0]           cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W:0]   sum_x;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   rsh;
  logic signed [OUT_W-1:0] q_next;
  logic                    first;
  logic                    last;
  logic                    xfer;

  assign first  = (cnt == '0);
  assign last   = (cnt == LASTC);
  assign prod_x = {{(ACC_W-PROD_W){io.in_prod[PROD_W-1]}}, io.in_prod};

  // Only the closing product of a window can be held off by a full output.
  assign io.in_ready = !last || !io.out_valid || io.out_ready;
  assign xfer        = io.in_valid && io.in_ready;
  assign io.busy     = !first;

  // Next accumulator value and its requantized form for the closing edge.
  always_comb begin
    acc_next = (first ? io.bias : acc) + prod_x;
    sum_x    = {acc_next[ACC_W-1], acc_next};
    rnd      = '0;
    if (io.shift != 4'd0)
      rnd = (ACC_W+1)'(1) << (io.shift - 4'd1);
    rsh = (sum_x + rnd) >>> io.shift;
    if (io.relu_en && rsh < 0)
      rsh = '0;
    if (rsh > QMAX)
      q_next = QMAX[OUT_W-1:0];
    else if (rsh < QMIN)
      q_next = QMIN[OUT_W-1:0];
    else
      q_next = rsh[OUT_W-1:0];
  end

  // Running sum and tap counter; the counter wraps on the closing product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (xfer) begin
      acc <= acc_next;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Result register: loads on the closing product, clears when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.out_acc   <= '0;
      io.out_q     <= '0;
    end else if (xfer && last) begin
      io.out_valid <= 1'b1;
      io.out_acc   <= acc_next;
      io.out_q     <= q_next;
    end else if (io.out_valid && io.out_ready) begin
      io.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed windows with literal results plus
// random traffic, all tracked by a window-level reference model.
module tb_mac_accumulator;
  localparam int K = 9;

  logic clk;
  logic rst_n;

  mac_acc_if #(.PROD_W(16), .ACC_W(24), .OUT_W(8)) io ();

  mac_accumulator #(
    .PROD_W(16), .ACC_W(24), .KSIZE(K), .OUT_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    longint acc;
    longint q;
  } res_t;

  res_t   exp_q[$];
  int     mcnt = 0;
  longint wsum = 0;

  function automatic longint requant(longint s, int sh, bit relu);
    longint r;
    r = s;
    if (sh > 0) r = (s + (64'sd1 <<< (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  // Compare outputs against the model, then advance it by the coming edge.
  always @(negedge clk) begin
    bit   exp_rdy;
    bit   xfer;
    bit   drain;
    res_t r;
    if (!rst_n) begin
      exp_q.delete();
      mcnt = 0;
      wsum = 0;
      chk("rst_out_valid", io.out_valid, 0);
      chk("rst_busy", io.busy, 0);
    end else begin
      chk("out_valid", io.out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("out_acc", $signed(io.out_acc), exp_q[0].acc);
        chk("out_q", $signed(io.out_q), exp_q[0].q);
      end
      chk("busy", io.busy, mcnt != 0);
      exp_rdy = !(mcnt == K - 1 && exp_q.size() != 0 && !io.out_ready);
      chk("in_ready", io.in_ready, exp_rdy);
      xfer  = io.in_valid && exp_rdy;
      drain = exp_q.size() != 0 && io.out_ready;
      if (drain) void'(exp_q.pop_front());
      if (xfer) begin
        if (mcnt == 0) wsum = $signed(io.bias);
        wsum += $signed(io.in_prod);
        if (mcnt == K - 1) begin
          r.acc = wsum;
          r.q   = requant(wsum, int'(io.shift), io.relu_en);
          exp_q.push_back(r);
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(int p, longint b, int s, bit r);
    bit ok;
    io.in_valid = 1'b1;
    io.in_prod  = 16'(p);
    io.bias     = 24'(b);
    io.shift    = 4'(s);
    io.relu_en  = r;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = io.in_ready;
      @(posedge clk);
      #2;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic window(int p0, int step, longint b, int s, bit r);
    for (int i = 0; i < K; i++) send(p0 + i * step, b, s, r);
  endtask

  task automatic res(string n, longint a, longint q);
    chk({n, "_valid"}, io.out_valid, 1);
    chk({n, "_acc"}, $signed(io.out_acc), a);
    chk({n, "_q"}, $signed(io.out_q), q);
  endtask

  initial begin
    int     pulses;
    longint t0;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_prod   = '0;
    io.bias      = '0;
    io.shift     = '0;
    io.relu_en   = 1'b0;
    io.out_ready = 1'b1;
    cyc(2);
    chk("reset_out_valid", io.out_valid, 0);
    chk("reset_out_acc", io.out_acc, 0);
    chk("reset_out_q", io.out_q, 0);
    chk("reset_busy", io.busy, 0);
    rst_n = 1'b1;
    cyc(1);

    window(1, 1, 3, 3, 0);
    res("round", 48, 6);
    io.in_valid = 1'b0;
    cyc(1);
    window(1, 1, 3, 0, 0);
    res("noshift", 48, 48);

    window(16384, 0, 0, 8, 0);
    res("possat", 147456, 127);
    window(16384, 0, -147456, 8, 0);
    res("zero", 0, 0);

    window(-100, 0, 0, 2, 0);
    res("negsat", -900, -128);
    window(-100, 0, 0, 2, 1);
    res("relu", -900, 0);

    window(1, 1, 3, 0, 0);
    io.out_ready = 1'b0;
    for (int i = 0; i < K - 1; i++) send(1, 0, 0, 0);
    #1;
    chk("bp_in_ready", io.in_ready, 0);
    cyc(3);
    res("bp_hold", 48, 48);
    chk("bp_busy", io.busy, 1);
    io.out_ready = 1'b1;
    cyc(1);
    io.out_ready = 1'b0;
    io.in_valid  = 1'b0;
    res("bp_drain", 9, 9);
    chk("bp_busy_done", io.busy, 0);
    io.out_ready = 1'b1;
    cyc(1);

    for (int i = 0; i < 4; i++) begin
      send(10, 0, 0, 0);
      io.in_valid = 1'b0;
      cyc(2);
    end
    chk("gap_busy", io.busy, 1);
    chk("gap_valid", io.out_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", io.out_valid, 0);
    chk("arst_acc", io.out_acc, 0);
    chk("arst_q", io.out_q, 0);
    chk("arst_busy", io.busy, 0);
    @(negedge clk);
    cyc(1);
    rst_n = 1'b1;
    window(2, 0, 0, 0, 0);
    res("after_rst", 18, 18);

    pulses = 0;
    t0 = $time;
    for (int i = 0; i < 3 * K; i++) begin
      send(i, 5, 0, 0);
      if (io.out_valid) pulses++;
    end
    chk("b2b_cycles", ($time - t0) / 10, 3 * K);
    chk("b2b_pulses", pulses, 3);
    io.in_valid = 1'b0;
    cyc(2);

    for (int i = 0; i < 600; i++) begin
      io.in_valid  = ($urandom % 4) != 0;
      io.in_prod   = 16'($urandom);
      io.bias      = 24'(int'($urandom_range(0, 8388607)) - 4194304);
      io.shift     = 4'($urandom);
      io.relu_en   = 1'($urandom);
      io.out_ready = ($urandom % 3) != 0;
      cyc(1);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
